context_loader: RTL

//  Transmit side of the PE context-load interface. Streams context words from the

---
 rtl/context_loader_pkg.sv | 20 ++
 rtl/context_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/context_loader_pkg.sv
// Shared constants for the context-load datapath: context word geometry,
// FSM state encodings (shared with context_pointer) and request validation.
package context_loader_pkg;

    localparam int unsigned CTX_WIDTH  = 120;  // data bus MSB index
    localparam int unsigned CTX_DEPTH  = 16;   // entries per PE context cache
    localparam int unsigned CTX_NUM_PE = 16;   // PEs per array

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_LAUNCH = 2'd2;

    // A request is legal when at least one PE is selected and 1 <= len <= depth.
    function automatic logic req_legal(input logic       mask_any,
                                       input logic [4:0] len,
                                       input int unsigned depth);
        return mask_any && (len != 5'd0) && (32'(len) <= depth);
    endfunction

endpackage

// File: rtl/context_loader.sv
// Transmit side of the PE context-load interface: reads len words from the
// context memory, writes them into the selected PE caches one word per cycle,
// then issues a single start pulse.
module context_loader
    import context_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = CTX_WIDTH,
    parameter int unsigned NUM_PE = CTX_NUM_PE,
    parameter int unsigned DEPTH  = CTX_DEPTH,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic [NUM_PE-1:0] req_pe_mask,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [4:0]        req_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH:0]    mem_rdata,
    output logic [WIDTH:0]    data,
    output logic [NUM_PE-1:0] wr_en,
    output logic [3:0]        wr_idx,
    output logic              start
);

    logic [1:0]        state_q,    state_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wr_vld_q,   wr_vld_d;
    logic [NUM_PE-1:0] wr_en_q,    wr_en_d;
    logic [3:0]        wr_idx_q,   wr_idx_d;
    logic              start_q,    start_d;
    logic [NUM_PE-1:0] mask_q,     mask_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [4:0]        len_q,      len_d;
    logic [4:0]        rd_cnt_q,   rd_cnt_d;
    logic [4:0]        wr_cnt_q,   wr_cnt_d;
    logic [WIDTH:0]    data_hold_q, data_hold_d;
    logic [WIDTH:0]    data_o;

    // Next-state logic for the IDLE -> STREAM -> LAUNCH sequence and both pipe stages.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        wr_vld_d    = 1'b0;
        wr_en_d     = '0;
        wr_idx_d    = wr_idx_q;
        start_d     = 1'b0;
        mask_d      = mask_q;
        base_d      = base_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;

        // Memory data is only valid in the write cycle, so the bus is
        // forwarded then and held from a register otherwise.
        data_o      = wr_vld_q ? mem_rdata : data_hold_q;
        data_hold_d = data_o;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!req_legal(|req_pe_mask, req_len, DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        // Word 0 is read in the first STREAM cycle, so its
                        // strobe is registered at the accepting edge.
                        mask_d     = req_pe_mask;
                        base_d     = req_base;
                        len_d      = req_len;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = req_base;
                        rd_cnt_d   = 5'd1;
                        wr_cnt_d   = 5'd0;
                        busy_d     = 1'b1;
                        state_d    = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (rd_cnt_q < len_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(rd_cnt_q);
                    rd_cnt_d   = rd_cnt_q + 5'd1;
                end
                if (mem_rd_q) begin
                    wr_vld_d = 1'b1;
                    wr_en_d  = mask_q;
                    wr_idx_d = wr_cnt_q[3:0];
                    wr_cnt_d = wr_cnt_q + 5'd1;
                end
                if (wr_vld_q && (wr_cnt_q == len_q)) begin
                    start_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            wr_vld_q    <= 1'b0;
            wr_en_q     <= '0;
            wr_idx_q    <= '0;
            start_q     <= 1'b0;
            mask_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            wr_vld_q    <= wr_vld_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            start_q     <= start_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign data     = data_o;
    assign wr_en    = wr_en_q;
    assign wr_idx   = wr_idx_q;
    assign start    = start_q;

endmodule
